// File: rtl/sweep_pkg.sv
// Shared types and constants for the truth-table sweeper and its benches.
// Exports the sweep FSM state enum, the default input count, and the golden table of f.
// f: S = (~A | C) & (A | B) & (B | C); bit i of F_TRUTH is S for input vector i (A=MSB).
package sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int N_IN_DEF = 3;

    localparam logic [7:0] F_TRUTH = 8'hAC;

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// Down-counter that times how long each vector is held before S is sampled.
// Ports: clk/rst (sync, active-high), load_i restarts at SETTLE-1, en_i counts down,
//        expired_o high while the count is zero (the final hold cycle).
module settle_timer #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Loaded on the edge that enters APPLY, so the first APPLY cycle already
    // sees SETTLE-1 and the hold lasts exactly SETTLE cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CW'(SETTLE - 1);
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps every input vector of an external combinational function, captures S
// per vector into a truth-table word, and compares it against a golden table.
// Ports: start (sampled in IDLE), s_in (S of the DUT), vec_out (A=MSB..C=LSB),
//        busy/done status, table_out/mismatch_cnt/pass results held until next start.
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int                      N_IN     = N_IN_DEF,
    parameter int                      SETTLE   = 1,
    parameter logic [(2**N_IN)-1:0]    EXPECTED = F_TRUTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   s_in,
    output logic [N_IN-1:0]        vec_out,
    output logic                   busy,
    output logic                   done,
    output logic [(2**N_IN)-1:0]   table_out,
    output logic [N_IN:0]          mismatch_cnt,
    output logic                   pass
);

    localparam int NVEC = 2**N_IN;
    localparam int CW   = N_IN + 1;

    state_e            state_q;
    state_e            state_d;
    logic [N_IN-1:0]   idx_q;
    logic [NVEC-1:0]   table_q;
    logic [CW-1:0]     cnt_q;
    logic              pass_q;

    logic              tmr_load;
    logic              tmr_expired;
    logic              last_vec;
    logic              miss;

    assign last_vec = (idx_q == N_IN'(NVEC - 1));
    assign miss     = (s_in != EXPECTED[idx_q]);

    settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (tmr_load),
        .en_i      (state_q == APPLY),
        .expired_o (tmr_expired)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the timer is reloaded on every transition into APPLY
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = APPLY;
                    tmr_load = 1'b1;
                end
            end
            APPLY: begin
                if (tmr_expired) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (last_vec) begin
                    state_d = DONE;
                end else begin
                    state_d  = APPLY;
                    tmr_load = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Capture and compare. pass is resolved on the last SAMPLE edge so it is
    // already valid during DONE and then simply holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            table_q <= '0;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        idx_q   <= '0;
                        table_q <= '0;
                        cnt_q   <= '0;
                        pass_q  <= 1'b0;
                    end
                end
                SAMPLE: begin
                    table_q[idx_q] <= s_in;
                    cnt_q          <= cnt_q + CW'(miss);
                    if (last_vec) begin
                        pass_q <= (cnt_q == '0) && !miss;
                    end else begin
                        idx_q <= idx_q + N_IN'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs
    always_comb begin
        vec_out = '0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            APPLY, SAMPLE: begin
                vec_out = idx_q;
                busy    = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign table_out    = table_q;
    assign mismatch_cnt = cnt_q;
    assign pass         = pass_q;

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequential stimulus-and-capture stage wrapped around the 3-input combinational function block `f`, where S = (~A | C) & (A | B) & (B | C).
- On a `start` request it walks the input vector through every combination, drives A/B/C, and samples S after a settle delay.
- Assembles the sampled values into a truth-table word, compares each bit against an expected constant, and reports pass/fail with a `done` pulse.
- Replaces the hand-written `initial`-block sweep with a synthesizable, reusable checker.

Parameters:
- N_IN, 3, number of function inputs; sweep covers 2**N_IN vectors.
- SETTLE, 1, cycles each vector is held before S is sampled; legal range >= 1.
- EXPECTED, 8'hAC, golden truth table; bit i = expected S for vector i. 0xAC is the table of `f`.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a sweep; sampled only in IDLE.
- s_in  input  1  S output of the function under test (combinational).
- vec_out  output  N_IN  applied input vector; MSB=A, then B, LSB=C.
- busy  output  1  high from the cycle after start is accepted through the DONE cycle.
- done  output  1  one-cycle pulse when the sweep completes.
- table_out  output  2**N_IN  captured S per vector; bit i = vector i.
- mismatch_cnt  output  N_IN+1  count of bits where the captured S differs from EXPECTED.
- pass  output  1  set in DONE when mismatch_cnt==0.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - rst is sampled on the clk rising edge only.
  - In the cycle after rst=1: state=IDLE, vec_out=0, busy=0, done=0, table_out=0, mismatch_cnt=0, pass=0, idx=0, settle counter=0.
  - rst has priority over every other event, including mid-sweep; no partial results survive.
- States: IDLE, APPLY, SAMPLE, DONE.
- IDLE:
  - vec_out=0, busy=0.
  - If start=1: next state is APPLY, idx=0; table_out, mismatch_cnt and pass are cleared on that edge.
- APPLY:
  - vec_out=idx, busy=1.
  - Stays SETTLE cycles (counter 0..SETTLE-1), then goes to SAMPLE.
- SAMPLE:
  - Lasts one cycle; vec_out is still idx.
  - On the exit edge: table_out[idx] <= s_in; mismatch_cnt increments by 1 if s_in != EXPECTED[idx].
  - If idx == 2**N_IN-1, next state is DONE; otherwise idx increments and the next state is APPLY.
- DONE:
  - Lasts one cycle: done=1, busy=1, pass=(mismatch_cnt==0) using the final count including the last sample.
  - Next state is IDLE.
- Timing, with start accepted at edge 0:
  - Vector k enters APPLY at cycle 1 + k*(SETTLE+1).
  - Vector k is sampled at cycle 1 + k*(SETTLE+1) + SETTLE.
  - done is asserted at cycle 1 + 2**N_IN*(SETTLE+1); with defaults this is cycle 17.
- Result holding: table_out, mismatch_cnt and pass hold after DONE until the next accepted start or rst.
- start while busy (APPLY/SAMPLE/DONE): ignored, with no queuing. start held high continuously restarts a sweep each time the FSM returns to IDLE.
- Widths and wrap:
  - idx is N_IN bits and never wraps mid-sweep; the terminal compare stops it at 2**N_IN-1.
  - mismatch_cnt is N_IN+1 bits, so it holds the maximum 2**N_IN without overflow.
- s_in is sampled only in SAMPLE; glitches during APPLY are don't-care.

Decomposition:
- Shared package `sweep_pkg`:
  - State enum {IDLE, APPLY, SAMPLE, DONE}.
  - Default N_IN constant.
  - Constant F_TRUTH = 8'hAC, the golden table of `f`, reused by benches.
- One natural sub-module: `settle_timer`, a SETTLE-cycle down-counter with load/expire. The FSM, capture and compare logic stay in the top.
- `f` is not instantiated inside; the bench or integration level connects vec_out to A/B/C and S to s_in.

Test Plan:
- Functional sweep: rst, then a 1-cycle start, with `f` connected -> vec_out steps 0..7, each held 2 cycles; table_out=8'hAC, mismatch_cnt=0, pass=1; done pulses once at cycle 17.
- Stuck-at-0: s_in tied 0 -> table_out=8'h00, mismatch_cnt=4, pass=0, done at cycle 17.
- Stuck-at-1: s_in tied 1 -> table_out=8'hFF, mismatch_cnt=4, pass=0.
- Start during busy: start pulses at cycles 5 and 12 -> no effect, single done at cycle 17. start held high -> second sweep begins in APPLY at cycle 19 and gives identical results.
- Reset mid-sweep: rst=1 at cycle 8 -> next cycle all outputs 0 and state IDLE; a fresh start then yields 8'hAC and pass=1.
- Parameter: SETTLE=3 -> each vector held 4 cycles, done at cycle 33, table_out=8'hAC.
